// File: rtl/alu_op_sequencer.sv
// Command/response front end for a 64-bit combinational ALU. Registers the operands,
// waits a fixed settle time, captures the result and flags, and keeps saturating
// operation and overflow counters.
module alu_op_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,  // legal range 1..15
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  // Command channel
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [63:0]      cmd_a,
  input  logic [63:0]      cmd_b,
  input  logic             cmd_cin,
  input  logic [3:0]       cmd_sel,
  // ALU drive
  output logic [63:0]      alu_a,
  output logic [63:0]      alu_b,
  output logic             alu_cin,
  output logic [3:0]       alu_sel,
  // ALU result
  input  logic [63:0]      alu_o,
  input  logic             alu_cout,
  input  logic             alu_oflow,
  input  logic             alu_ntive,
  input  logic             alu_zero,
  // Response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_result,
  output logic [3:0]       rsp_flags,
  // Debug counters
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] oflow_count
);

  typedef enum logic [1:0] {StIdle, StSettle, StResp} state_e;

  // Counter reload value; the capture happens on the edge where the counter reads 0.
  localparam logic [3:0] SettleLoad = 4'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [63:0]      alu_a_q, alu_a_d;
  logic [63:0]      alu_b_q, alu_b_d;
  logic             alu_cin_q, alu_cin_d;
  logic [3:0]       alu_sel_q, alu_sel_d;
  logic [63:0]      result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [CNT_W-1:0] op_cnt_q, op_cnt_d;
  logic [CNT_W-1:0] ofl_cnt_q, ofl_cnt_d;

  // Next-state, operand capture, result capture and counter updates.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    alu_a_d   = alu_a_q;
    alu_b_d   = alu_b_q;
    alu_cin_d = alu_cin_q;
    alu_sel_d = alu_sel_q;
    result_d  = result_q;
    flags_d   = flags_q;
    op_cnt_d  = op_cnt_q;
    ofl_cnt_d = ofl_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          alu_a_d   = cmd_a;
          alu_b_d   = cmd_b;
          alu_cin_d = cmd_cin;
          alu_sel_d = cmd_sel;
          cnt_d     = SettleLoad;
          state_d   = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == 4'd0) begin
          result_d = alu_o;
          flags_d  = {alu_cout, alu_oflow, alu_ntive, alu_zero};
          if (op_cnt_q != CntMax) op_cnt_d = op_cnt_q + 1'b1;
          if (alu_oflow && (ofl_cnt_q != CntMax)) ofl_cnt_d = ofl_cnt_q + 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        // Returning to idle here means no accept can coincide with the response handshake.
        if (rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cin_q <= 1'b0;
      alu_sel_q <= '0;
      result_q  <= '0;
      flags_q   <= '0;
      op_cnt_q  <= '0;
      ofl_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      alu_a_q   <= alu_a_d;
      alu_b_q   <= alu_b_d;
      alu_cin_q <= alu_cin_d;
      alu_sel_q <= alu_sel_d;
      result_q  <= result_d;
      flags_q   <= flags_d;
      op_cnt_q  <= op_cnt_d;
      ofl_cnt_q <= ofl_cnt_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign rsp_valid   = (state_q == StResp);
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_cin     = alu_cin_q;
  assign alu_sel     = alu_sel_q;
  assign rsp_result  = result_q;
  assign rsp_flags   = flags_q;
  assign op_count    = op_cnt_q;
  assign oflow_count = ofl_cnt_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one default instance (settle 2, 16-bit counters)
// and one with settle 1 and 4-bit counters, each driving a behavioural ALU.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] cmd_a = '0, cmd_b = '0;
  logic        cmd_cin = 1'b0;
  logic [3:0]  cmd_sel = '0;
  logic        cmd_valid0 = 1'b0, cmd_valid1 = 1'b0;
  logic        rsp_ready0 = 1'b0, rsp_ready1 = 1'b0;

  logic        cmd_ready0, cmd_ready1, rsp_valid0, rsp_valid1;
  logic [63:0] alu_a0, alu_b0, alu_a1, alu_b1, alu_o0, alu_o1;
  logic        alu_cin0, alu_cin1;
  logic [3:0]  alu_sel0, alu_sel1, rsp_flags0, rsp_flags1;
  logic        cout0, oflow0, ntive0, zero0, cout1, oflow1, ntive1, zero1;
  logic [63:0] rsp_result0, rsp_result1;
  logic [15:0] op_count0, oflow_count0;
  logic [3:0]  op_count1, oflow_count1;

  int n_vec = 0;
  int n_err = 0;
  int ops0 = 0, ofl0 = 0, ops1 = 0, ofl1 = 0;
  logic [67:0] q0[$];
  logic [67:0] q1[$];

  always #5 clk = ~clk;

  // Bench ALU: sel 4 is A+B+Cin; anything else is A^B with no flags but N/Z.
  function automatic logic [67:0] alu_model(input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic [3:0] sel);
    logic [64:0] s;
    logic [63:0] o;
    logic        co, ov;
    if (sel == 4'd4) begin
      s  = {1'b0, a} + {1'b0, b} + 65'(cin);
      o  = s[63:0];
      co = s[64];
      ov = (a[63] == b[63]) && (o[63] != a[63]);
    end else begin
      o  = a ^ b;
      co = 1'b0;
      ov = 1'b0;
    end
    return {o, co, ov, o[63], (o == 64'd0)};
  endfunction

  assign {alu_o0, cout0, oflow0, ntive0, zero0} = alu_model(alu_a0, alu_b0, alu_cin0, alu_sel0);
  assign {alu_o1, cout1, oflow1, ntive1, zero1} = alu_model(alu_a1, alu_b1, alu_cin1, alu_sel1);

  alu_op_sequencer dut0 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
    .alu_a(alu_a0), .alu_b(alu_b0), .alu_cin(alu_cin0), .alu_sel(alu_sel0),
    .alu_o(alu_o0), .alu_cout(cout0), .alu_oflow(oflow0), .alu_ntive(ntive0),
    .alu_zero(zero0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_result(rsp_result0), .rsp_flags(rsp_flags0),
    .op_count(op_count0), .oflow_count(oflow_count0)
  );

  alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cin(cmd_cin), .cmd_sel(cmd_sel),
    .alu_a(alu_a1), .alu_b(alu_b1), .alu_cin(alu_cin1), .alu_sel(alu_sel1),
    .alu_o(alu_o1), .alu_cout(cout1), .alu_oflow(oflow1), .alu_ntive(ntive1),
    .alu_zero(zero1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1),
    .rsp_result(rsp_result1), .rsp_flags(rsp_flags1),
    .op_count(op_count1), .oflow_count(oflow_count1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, " rdy/vld0"}, {cmd_ready0, rsp_valid0}, 2'b10);
    check({tag, " rdy/vld1"}, {cmd_ready1, rsp_valid1}, 2'b10);
    check({tag, " alu0"}, {alu_a0, alu_b0, alu_cin0, alu_sel0}, '0);
    check({tag, " alu1"}, {alu_a1, alu_b1, alu_cin1, alu_sel1}, '0);
    check({tag, " rsp0"}, {rsp_result0, rsp_flags0}, '0);
    check({tag, " rsp1"}, {rsp_result1, rsp_flags1}, '0);
    check({tag, " cnt0"}, {op_count0, oflow_count0}, '0);
    check({tag, " cnt1"}, {op_count1, oflow_count1}, '0);
  endtask

  // Present a command in idle, push its expected response, then measure capture latency.
  task automatic accept(input int inst, input logic [63:0] a, input logic [63:0] b,
                        input logic cin, input logic [3:0] sel, input logic [67:0] exp);
    int n;
    cmd_a = a; cmd_b = b; cmd_cin = cin; cmd_sel = sel;
    if (inst == 1) cmd_valid1 = 1'b1; else cmd_valid0 = 1'b1;
    check("cmd_ready before accept", (inst == 1) ? cmd_ready1 : cmd_ready0, 1'b1);
    if (inst == 1) q1.push_back(exp); else q0.push_back(exp);
    tick();
    if (inst == 1) cmd_valid1 = 1'b0; else cmd_valid0 = 1'b0;
    check("alu drive", (inst == 1) ? {alu_a1, alu_b1, alu_cin1, alu_sel1}
                                   : {alu_a0, alu_b0, alu_cin0, alu_sel0}, {a, b, cin, sel});
    n = 0;
    do begin
      tick();
      n++;
    end while (!((inst == 1) ? rsp_valid1 : rsp_valid0) && n < 20);
    check("capture latency", n, (inst == 1) ? 1 : 2);
  endtask

  // Pop and compare the response, optionally hold backpressure, then complete the handshake.
  task automatic respond(input int inst, input int hold);
    logic [67:0] exp;
    logic [67:0] obs;
    if (((inst == 1) ? q1.size() : q0.size()) == 0) begin
      check("scoreboard empty", 1, 0);
      return;
    end
    if (inst == 1) exp = q1.pop_front(); else exp = q0.pop_front();
    if (inst == 1) begin
      ops1++; if (exp[2]) ofl1++;
    end else begin
      ops0++; if (exp[2]) ofl0++;
    end
    obs = (inst == 1) ? {rsp_result1, rsp_flags1} : {rsp_result0, rsp_flags0};
    check("rsp result/flags", obs, exp);
    if (inst == 1) check("counters1", {op_count1, oflow_count1}, {4'(sat(ops1, 15)), 4'(sat(ofl1, 15))});
    else check("counters0", {op_count0, oflow_count0}, {16'(ops0), 16'(ofl0)});
    for (int i = 0; i < hold; i++) begin
      if (inst == 1) rsp_ready1 = 1'b0; else rsp_ready0 = 1'b0;
      tick();
      obs = (inst == 1) ? {rsp_result1, rsp_flags1} : {rsp_result0, rsp_flags0};
      check("hold valid/ready", (inst == 1) ? {rsp_valid1, cmd_ready1} : {rsp_valid0, cmd_ready0},
            2'b10);
      check("hold data", obs, exp);
    end
    if (inst == 1) rsp_ready1 = 1'b1; else rsp_ready0 = 1'b1;
    tick();
    if (inst == 1) rsp_ready1 = 1'b0; else rsp_ready0 = 1'b0;
    check("post handshake", (inst == 1) ? {rsp_valid1, cmd_ready1} : {rsp_valid0, cmd_ready0},
          2'b01);
  endtask

  initial begin
    logic [63:0] a, b;
    int          n;
    // Power-on reset.
    tick(); tick();
    check_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Add with carry out, no signed overflow.
    accept(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd4,
           {64'h7FFF_FFFF_FFFF_FFFE, 4'b1000});
    respond(0, 0);
    // Signed overflow.
    accept(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 4'd4, {64'h8000_0000_0000_0000, 4'b0110});
    respond(0, 0);
    // Zero result; rsp_ready raised early must not matter.
    rsp_ready0 = 1'b1;
    accept(0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 4'd4, {64'd0, 4'b1001});
    respond(0, 0);
    // Non-add select passes through unmodified.
    accept(0, 64'hDEAD_BEEF_0000_1234, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd3,
           alu_model(64'hDEAD_BEEF_0000_1234, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 4'd3));
    // Backpressure with a second command waiting; it must not be taken until after handshake.
    cmd_a = 64'h1111; cmd_b = 64'h2222; cmd_cin = 1'b1; cmd_sel = 4'd4;
    cmd_valid0 = 1'b1;
    respond(0, 10);
    check("alu held during resp", alu_a0, 64'hDEAD_BEEF_0000_1234);
    accept(0, 64'h1111, 64'h2222, 1'b1, 4'd4, {64'h3334, 4'b0000});
    respond(0, 0);

    // Settle-1 instance: 19 overflowing ops saturate both 4-bit counters.
    for (int i = 0; i < 19; i++) begin
      a = 64'h7FFF_FFFF_FFFF_FFFF;
      b = 64'(i + 1);
      accept(1, a, b, 1'b0, 4'd4, alu_model(a, b, 1'b0, 4'd4));
      respond(1, 0);
    end
    check("saturated counters1", {op_count1, oflow_count1}, 8'hFF);

    // Reset mid-settle aborts the operation and clears counters.
    cmd_a = 64'h5; cmd_b = 64'h6; cmd_cin = 1'b0; cmd_sel = 4'd4;
    cmd_valid0 = 1'b1;
    tick();
    cmd_valid0 = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_state("abort");
    tick();
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid0) n++;
    end
    check("no rsp after abort", n, 0);
    check("idle after abort", cmd_ready0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
